forward_ctrl: RTL and testbench
===============================

# forward_ctrl

Forwarding and load-use hazard controller for the 5-stage pipelined core. It tracks the destination-register information of the instructions in EX, MEM and WB in its own shadow pipeline registers. From those it drives the 2-bit select of the two EX-stage operand 3-to-1 muxes, and it asserts a one-cycle stall when a load is followed by a dependent instruction. It is the producer side of the operand-mux select interface: the muxes consume `fwd_a_sel_o` and `fwd_b_sel_o` directly.

## Interface
- `CNT_W`, default 16: width of the saturating stall performance counter.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-low.
- `id_valid_i` input 1: ID stage holds a real instruction.
- `id_rs1_i`, `id_rs2_i` input 5 each: source register indices of the ID instruction.
- `id_use_rs1_i`, `id_use_rs2_i` input 1 each: the ID instruction actually reads rs1 / rs2.
- `id_rd_i` input 5: destination register index of the ID instruction.
- `id_reg_write_i` input 1: the ID instruction writes the register file.
- `id_mem_read_i` input 1: the ID instruction is a load.
- `flush_i` input 1: a taken branch was resolved in EX; the ID instruction must not enter EX.
- `stall_o` output 1: hold PC and IF/ID, and insert a bubble into EX.
- `fwd_a_sel_o`, `fwd_b_sel_o` output 2 each: operand select for the instruction in EX.
  - 00 = register-file value.
  - 01 = MEM/WB write-back data.
  - 10 = EX/MEM ALU result.
  - 11 is never driven.
- `stall_cnt_o` output CNT_W: number of stall cycles since reset, saturating.

## Operation
- Shadow records:
  - EX: valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, mem_read.
  - MEM: valid, rd, reg_write, mem_read.
  - WB: valid, rd, reg_write.
- Every clock (when `rst_i`=1):
  - WB ← MEM.
  - MEM ← EX.
  - EX ← bubble if `flush_i` or `stall_o`; otherwise EX ← the ID fields, with valid = `id_valid_i`.
  - A bubble has all fields zero.
- Load-use stall (combinational), `stall_o` = 1 when all of the following hold:
  - `id_valid_i` = 1;
  - `flush_i` = 0;
  - EX.valid, EX.mem_read and EX.reg_write are all 1;
  - EX.rd ≠ 0;
  - (`id_use_rs1_i` and `id_rs1_i` = EX.rd) or (`id_use_rs2_i` and `id_rs2_i` = EX.rd).
- `flush_i` has priority over the stall: a flushed instruction never stalls.
- Forwarding for operand A (combinational from the shadow registers only); operand B is identical with rs2 / use_rs2.
  - If EX.valid, EX.use_rs1 and EX.rs1 ≠ 0:
    - MEM.valid, MEM.reg_write, !MEM.mem_read and MEM.rd = EX.rs1 → 10;
    - else WB.valid, WB.reg_write and WB.rd = EX.rs1 → 01;
    - else → 00.
  - Otherwise → 00.
  - MEM has priority over WB, so the youngest producer wins.
  - x0 is never forwarded.
  - A load in MEM is never a forwarding source. The stall guarantees that a load's consumer reaches EX only once the load is in WB.
- Stall counter:
  - Increments by 1 on each clock edge where `stall_o` = 1.
  - Holds at all-ones; no wrap.

## Timing
- Reset (`rst_i` = 0 at a rising edge): all shadow records invalid, `stall_cnt_o` = 0. In the following cycle `stall_o` = 0 and both selects = 00, regardless of the ID inputs, unless the stall condition is met from the ID inputs alone, which is impossible because EX is invalid.
- Reset asserted mid-stall or mid-forward: takes effect at the next edge and discards all in-flight records.
- Selects are valid in the same cycle the consumer occupies EX; there are no registered outputs besides the counter.
- A dependency one instruction back forwards with select 10. A dependency two instructions back forwards with select 01. A dependency three back selects 00; the register file handles write-before-read.
- A load-use stall lasts exactly 1 cycle: the next cycle EX holds a bubble, so the condition clears.
- When `flush_i` and the stall condition coincide: `stall_o` = 0, EX receives a bubble, and the counter does not increment.
- Back-to-back loads that each feed the next instruction: one stall per pair.

## Test plan
- Reset and quiescent ID: hold `rst_i` = 0 for 2 cycles, then release → `stall_o` = 0, selects 00, `stall_cnt_o` = 0.
- ALU chain, forward from EX/MEM and MEM/WB:
  - Stimulus: `add x5,x1,x2` then `sub x6,x5,x5` → when sub is in EX, A = B = 10.
  - Insert one independent op between them instead → both selects 01.
- Priority and x0:
  - Two consecutive writers of x7, then a reader of x7 → select 10 (younger wins).
  - A writer of x0 followed by a reader of x0 → select 00.
- Load-use:
  - Stimulus: `lw x3,0(x4)` then `add x8,x3,x1` → `stall_o` = 1 for exactly 1 cycle.
  - Then add enters EX with A = 01 and B = 00.
  - `stall_cnt_o` = 1.
- Flush versus stall: same load/add pair with `flush_i` = 1 in the stall cycle → `stall_o` = 0, the bubble enters EX, selects stay 00, the counter is unchanged.
- Counter saturation: with CNT_W = 4, drive 20 load-use pairs → `stall_cnt_o` holds at 15.

Source files
------------

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage core.
// Shadows EX/MEM/WB destination info and drives the EX operand mux selects plus a load-use stall.

module fwd_sel (
   input  logic       ex_valid,
   input  logic       use_rs,
   input  logic [4:0] rs,
   input  logic       mem_valid,
   input  logic       mem_reg_write,
   input  logic       mem_mem_read,
   input  logic [4:0] mem_rd,
   input  logic       wb_valid,
   input  logic       wb_reg_write,
   input  logic [4:0] wb_rd,
   output logic [1:0] sel
);
   always_comb begin
      sel = 2'b00;
      if (ex_valid && use_rs && (rs != 5'd0)) begin
         // a load in MEM has no data yet; the stall keeps its consumer out of EX until WB
         if (mem_valid && mem_reg_write && !mem_mem_read && (mem_rd == rs))
            sel = 2'b10;
         else if (wb_valid && wb_reg_write && (wb_rd == rs))
            sel = 2'b01;
      end
   end
endmodule

module forward_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       id_rd_i,
   input  logic             id_reg_write_i,
   input  logic             id_mem_read_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic [1:0]       fwd_a_sel_o,
   output logic [1:0]       fwd_b_sel_o,
   output logic [CNT_W-1:0] stall_cnt_o
);
   localparam int NUM_OPS = 2;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use_rs1;
      logic       use_rs2;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } ex_rec_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } mem_rec_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
   } wb_rec_t;

   ex_rec_t  ex_q, ex_d;
   mem_rec_t mem_q;
   wb_rec_t  wb_q;
   logic     src_hit;

   assign src_hit = (id_use_rs1_i && (id_rs1_i == ex_q.rd)) ||
                    (id_use_rs2_i && (id_rs2_i == ex_q.rd));

   // flush wins: a squashed instruction never holds the front end
   assign stall_o = id_valid_i && !flush_i && ex_q.valid && ex_q.mem_read &&
                    ex_q.reg_write && (ex_q.rd != 5'd0) && src_hit;

   always_comb begin
      ex_d = '0;
      if (!flush_i && !stall_o) begin
         ex_d.valid     = id_valid_i;
         ex_d.rs1       = id_rs1_i;
         ex_d.rs2       = id_rs2_i;
         ex_d.use_rs1   = id_use_rs1_i;
         ex_d.use_rs2   = id_use_rs2_i;
         ex_d.rd        = id_rd_i;
         ex_d.reg_write = id_reg_write_i;
         ex_d.mem_read  = id_mem_read_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_o <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                    mem_read: ex_q.mem_read};
         wb_q  <= '{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
         if (stall_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end

   logic [NUM_OPS-1:0][4:0] op_rs;
   logic [NUM_OPS-1:0]      op_use;
   logic [NUM_OPS-1:0][1:0] op_sel;

   assign op_rs  = {ex_q.rs2, ex_q.rs1};
   assign op_use = {ex_q.use_rs2, ex_q.use_rs1};

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
      fwd_sel u_sel (
         .ex_valid      (ex_q.valid),
         .use_rs        (op_use[g]),
         .rs            (op_rs[g]),
         .mem_valid     (mem_q.valid),
         .mem_reg_write (mem_q.reg_write),
         .mem_mem_read  (mem_q.mem_read),
         .mem_rd        (mem_q.rd),
         .wb_valid      (wb_q.valid),
         .wb_reg_write  (wb_q.reg_write),
         .wb_rd         (wb_q.rd),
         .sel           (op_sel[g])
      );
   end

   assign fwd_a_sel_o = op_sel[0];
   assign fwd_b_sel_o = op_sel[1];
endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: expectations queued when an instruction is driven, checked mid-cycle.

module tb_forward_ctrl;
   localparam int CNT_W = 4;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             id_valid_i;
   logic [4:0]       id_rs1_i, id_rs2_i, id_rd_i;
   logic             id_use_rs1_i, id_use_rs2_i, id_reg_write_i, id_mem_read_i;
   logic             flush_i;
   logic             stall_o;
   logic [1:0]       fwd_a_sel_o, fwd_b_sel_o;
   logic [CNT_W-1:0] stall_cnt_o;

   forward_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .id_valid_i     (id_valid_i),
      .id_rs1_i       (id_rs1_i),
      .id_rs2_i       (id_rs2_i),
      .id_use_rs1_i   (id_use_rs1_i),
      .id_use_rs2_i   (id_use_rs2_i),
      .id_rd_i        (id_rd_i),
      .id_reg_write_i (id_reg_write_i),
      .id_mem_read_i  (id_mem_read_i),
      .flush_i        (flush_i),
      .stall_o        (stall_o),
      .fwd_a_sel_o    (fwd_a_sel_o),
      .fwd_b_sel_o    (fwd_b_sel_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int               id;
      logic             es;
      logic [1:0]       ea;
      logic [1:0]       eb;
      logic [CNT_W-1:0] ec;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   int               step_no = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   // drive one ID slot just after the edge, check at the falling edge, then advance
   task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb);
      exp_t e;
      id_valid_i = v;  id_rs1_i = rs1; id_rs2_i = rs2;
      id_use_rs1_i = u1; id_use_rs2_i = u2; id_rd_i = rd;
      id_reg_write_i = rw; id_mem_read_i = mr; flush_i = fl;
      sb.push_back('{id: step_no, es: es, ea: ea, eb: eb, ec: exp_cnt});
      @(negedge clk_i);
      e = sb.pop_front();
      checks++;
      assert (stall_o === e.es) else begin
         errors++;
         $error("FAIL step%0d stall observed=%0b expected=%0b", e.id, stall_o, e.es);
      end
      checks++;
      assert (fwd_a_sel_o === e.ea) else begin
         errors++;
         $error("FAIL step%0d sel_a observed=%0b expected=%0b", e.id, fwd_a_sel_o, e.ea);
      end
      checks++;
      assert (fwd_b_sel_o === e.eb) else begin
         errors++;
         $error("FAIL step%0d sel_b observed=%0b expected=%0b", e.id, fwd_b_sel_o, e.eb);
      end
      checks++;
      assert (stall_cnt_o === e.ec) else begin
         errors++;
         $error("FAIL step%0d stall_cnt observed=%0d expected=%0d", e.id, stall_cnt_o, e.ec);
      end
      if (!rst_i) exp_cnt = '0;
      else if (es && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      step_no++;
      @(posedge clk_i);
      #1;
   endtask

   task automatic nop(input logic [1:0] ea, input logic [1:0] eb);
      step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, ea, eb);
   endtask

   // lw x3,0(x4)
   task automatic ld(input logic es, input logic [1:0] ea, input logic [1:0] eb);
      step(1, 5'd4, 5'd0, 1, 0, 5'd3, 1, 1, 0, es, ea, eb);
   endtask

   // add x8,x3,x1
   task automatic use_add(input logic fl, input logic es, input logic [1:0] ea,
                          input logic [1:0] eb);
      step(1, 5'd3, 5'd1, 1, 1, 5'd8, 1, 0, fl, es, ea, eb);
   endtask

   initial begin
      rst_i = 1'b0;
      id_valid_i = 0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
      id_use_rs1_i = 0; id_use_rs2_i = 0; id_reg_write_i = 0; id_mem_read_i = 0;
      flush_i = 0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;

      nop(2'b00, 2'b00);                                        // reset state
      // add x5,x1,x2 ; sub x6,x5,x5
      step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00);
      nop(2'b10, 2'b10);
      nop(2'b00, 2'b00);
      nop(2'b00, 2'b00);
      // add x5,x1,x2 ; or x9,x10,x11 ; sub x6,x5,x5
      step(1, 5'd1,  5'd2,  1, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd10, 5'd11, 1, 1, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd5,  5'd5,  1, 1, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00);
      nop(2'b01, 2'b01);
      nop(2'b00, 2'b00);
      nop(2'b00, 2'b00);
      // two writers of x7, then add x12,x7,x0
      step(1, 5'd1, 5'd0, 1, 0, 5'd7,  1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd2, 5'd0, 1, 0, 5'd7,  1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd7, 5'd0, 1, 1, 5'd12, 1, 0, 0, 0, 2'b00, 2'b00);
      nop(2'b10, 2'b00);
      // writer of x0, then add x13,x0,x0
      step(1, 5'd1, 5'd0, 1, 0, 5'd0,  1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd0, 5'd0, 1, 1, 5'd13, 1, 0, 0, 0, 2'b00, 2'b00);
      nop(2'b00, 2'b00);
      nop(2'b00, 2'b00);
      nop(2'b00, 2'b00);
      // load-use: one stall, then add reaches EX with A from MEM/WB
      ld(0, 2'b00, 2'b00);
      use_add(0, 1, 2'b00, 2'b00);
      use_add(0, 0, 2'b00, 2'b00);
      nop(2'b01, 2'b00);
      nop(2'b00, 2'b00);
      nop(2'b00, 2'b00);
      // flush coinciding with the stall; follow with a reader of x8 to expose a leaked add
      ld(0, 2'b00, 2'b00);
      use_add(1, 0, 2'b00, 2'b00);
      step(1, 5'd8, 5'd0, 1, 1, 5'd14, 1, 0, 0, 0, 2'b00, 2'b00);
      nop(2'b00, 2'b00);
      nop(2'b00, 2'b00);
      // counter saturation
      for (int k = 0; k < 20; k++) begin
         ld(0, 2'b00, 2'b00);
         use_add(0, 1, 2'b00, 2'b00);
         use_add(0, 0, 2'b00, 2'b00);
         nop(2'b01, 2'b00);
      end
      // reset during a stall discards the load and clears the counter
      ld(0, 2'b00, 2'b00);
      rst_i = 1'b0;
      use_add(0, 1, 2'b00, 2'b00);
      rst_i = 1'b1;
      use_add(0, 0, 2'b00, 2'b00);
      nop(2'b00, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
